// File: rtl/dm_arbiter.sv
// Two-port arbiter and load/store sequencer in front of the word-wide dm_1k memory.
// Adds byte/half/word accesses; sub-word stores run as read-modify-write.
module dm_arbiter #(
    parameter int unsigned A_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [1:0]  a_size,
    input  logic        a_uns,
    input  logic [9:0]  a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [1:0]  b_size,
    input  logic        b_uns,
    input  logic [9:0]  b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [9:0]  dm_addr,
    output logic [31:0] dm_din,
    output logic        dm_we,
    input  logic [31:0] dm_dout
);

    typedef enum logic [1:0] {IDLE, ACC, WR, DONE} state_t;

    state_t      state;
    logic        owner_b;
    logic        last_b;
    logic        t_we;
    logic [1:0]  t_size;
    logic        t_uns;
    logic [9:0]  t_addr;
    logic [31:0] t_wdata;
    logic [31:0] mbuf;

    logic        grant_b;
    logic        s_we;
    logic [1:0]  s_size;
    logic        s_uns;
    logic [9:0]  s_addr;
    logic [31:0] s_wdata;
    logic        t_err;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Tie-break: round-robin against the last grant, or A wins outright.
    always_comb begin
        grant_b = 1'b0;
        if (a_req && b_req)
            grant_b = (A_PRIORITY == 0) ? !last_b : 1'b0;
        else
            grant_b = b_req;
    end

    always_comb begin
        s_we    = a_we;
        s_size  = a_size;
        s_uns   = a_uns;
        s_addr  = a_addr;
        s_wdata = a_wdata;
        if (grant_b) begin
            s_we    = b_we;
            s_size  = b_size;
            s_uns   = b_uns;
            s_addr  = b_addr;
            s_wdata = b_wdata;
        end
    end

    always_comb begin
        t_err = 1'b0;
        case (t_size)
            2'b11:   t_err = 1'b1;
            2'b10:   t_err = (t_addr[1:0] != 2'b00);
            2'b01:   t_err = t_addr[0];
            default: t_err = 1'b0;
        endcase
    end

    always_comb begin
        lane_b   = dm_dout[{t_addr[1:0], 3'b000} +: 8];
        lane_h   = dm_dout[{t_addr[1], 4'b0000} +: 16];
        load_val = dm_dout;
        if (t_size == 2'b00)
            load_val = t_uns ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
        else if (t_size == 2'b01)
            load_val = t_uns ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
    end

    always_comb begin
        merged = dm_dout;
        if (t_size == 2'b00)
            merged[{t_addr[1:0], 3'b000} +: 8] = t_wdata[7:0];
        else
            merged[{t_addr[1], 4'b0000} +: 16] = t_wdata[15:0];
    end

    // Write strobe is combinational so a word store lands at the end of ACC;
    // reset masks it so an interrupted transaction never reaches memory.
    always_comb begin
        dm_we  = !rst && ((state == ACC && t_we && t_size == 2'b10 && !t_err) || state == WR);
        dm_din = (state == WR) ? mbuf : t_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            dm_addr   <= '0;
            owner_b   <= 1'b0;
            last_b    <= 1'b1;
            t_we      <= 1'b0;
            t_size    <= '0;
            t_uns     <= 1'b0;
            t_addr    <= '0;
            t_wdata   <= '0;
            mbuf      <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        owner_b <= grant_b;
                        last_b  <= grant_b;
                        t_we    <= s_we;
                        t_size  <= s_size;
                        t_uns   <= s_uns;
                        t_addr  <= s_addr;
                        t_wdata <= s_wdata;
                        dm_addr <= {s_addr[9:2], 2'b00};
                        rsp_err <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    if (t_err) begin
                        rsp_err <= 1'b1;
                        state   <= DONE;
                    end else if (!t_we) begin
                        rsp_rdata <= load_val;
                        state     <= DONE;
                    end else if (t_size == 2'b10) begin
                        state <= DONE;
                    end else begin
                        mbuf  <= merged;
                        state <= WR;
                    end
                end
                WR: begin
                    state <= DONE;
                end
                DONE: begin
                    a_ack <= !owner_b;
                    b_ack <= owner_b;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
